// File: rtl/conf_sched_if.sv
// conf_sched_if
// Bundles every non-clock signal of the job sequencer.
//   CONFIG_VALID / CONFIG_READY / CONFIG_DATA : job handshake with the config register block
//   PORT_START / PORT_DONE                    : per-engine start and done pulses
//   JOB_DATA, BUSY, ERR, FRAMES_DONE          : job status seen by the rest of the system
// The slave modport is the sequencer's view; the master modport is the
// config block and engines' view.
interface conf_sched_if #(
    parameter int NREG   = 4,
    parameter int W      = 32,
    parameter int NPORTS = 2
);
    logic                  CONFIG_VALID;
    logic                  CONFIG_READY;
    logic [NREG*W-1:0]     CONFIG_DATA;
    logic [NPORTS-1:0]     PORT_START;
    logic [NPORTS-1:0]     PORT_DONE;
    logic [(NREG-1)*W-1:0] JOB_DATA;
    logic                  BUSY;
    logic                  ERR;
    logic [15:0]           FRAMES_DONE;

    modport master (
        output CONFIG_VALID, CONFIG_DATA, PORT_DONE,
        input  CONFIG_READY, PORT_START, JOB_DATA, BUSY, ERR, FRAMES_DONE
    );

    modport slave (
        input  CONFIG_VALID, CONFIG_DATA, PORT_DONE,
        output CONFIG_READY, PORT_START, JOB_DATA, BUSY, ERR, FRAMES_DONE
    );
endinterface

// File: rtl/conf_sched.sv
// conf_sched
// Job sequencer on the consumer side of the configuration register block.
// Accepts one job per CONFIG_VALID/CONFIG_READY handshake, then runs the
// enabled stream engines for the programmed number of frames. Each frame
// issues one start pulse per enabled engine and waits for all of their
// done pulses.
// Ports:
//   ACLK    : clock
//   ARESETN : synchronous active-low reset
//   bus     : conf_sched_if slave (config handshake, engine start/done, status)
// Register 0 of CONFIG_DATA is the command: [NPORTS-1:0] engine mask,
// [31:16] frame count (0 runs one frame). Registers 1..NREG-1 are passed
// through on JOB_DATA for the duration of the job.
module conf_sched #(
    parameter int NREG    = 4,
    parameter int W       = 32,
    parameter int NPORTS  = 2,
    parameter int TIMEOUT = 0
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    conf_sched_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [NPORTS-1:0]     mask;
    logic [NPORTS-1:0]     done_seen;
    logic [NPORTS-1:0]     done_now;
    logic [15:0]           frames_left;
    logic [15:0]           frames_done;
    logic [15:0]           frame_cnt;
    logic [31:0]           tmo_cnt;
    logic [(NREG-1)*W-1:0] job_data;
    logic                  err;
    logic                  accept;
    logic                  frame_complete;
    logic                  timed_out;
    logic                  last_frame;
    logic                  unused_cmd;

    // Command bits between the mask and the frame count are reserved.
    assign unused_cmd = ^bus.CONFIG_DATA[W-1:0];

    assign accept    = (state == ST_IDLE) && bus.CONFIG_VALID;
    assign frame_cnt = (bus.CONFIG_DATA[31:16] == 16'd0) ? 16'd1 : bus.CONFIG_DATA[31:16];
    assign done_now  = bus.PORT_DONE & mask;

    // Include this cycle's pulses so the frame closes on the cycle the last
    // done arrives; an empty mask therefore completes on the first WAIT cycle.
    assign frame_complete = (state == ST_WAIT) && ((done_seen | done_now) == mask);
    assign timed_out      = (TIMEOUT > 0) && (tmo_cnt == 32'(TIMEOUT - 1));
    assign last_frame     = (frames_left == 16'd1);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Completion is tested before timeout so a frame finishing on the
    // timeout cycle still counts as a success.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (frame_complete) begin
                    next_state = last_frame ? ST_DONE : ST_LAUNCH;
                end else if (timed_out) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.CONFIG_READY = (state == ST_IDLE);
        bus.BUSY         = (state != ST_IDLE);
        bus.PORT_START   = (state == ST_LAUNCH) ? mask : '0;
        bus.JOB_DATA     = job_data;
        bus.ERR          = err;
        bus.FRAMES_DONE  = frames_done;
    end

    // Done pulses are only collected in WAIT, so anything arriving during
    // LAUNCH or after an abort is dropped.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            mask        <= '0;
            done_seen   <= '0;
            frames_left <= 16'd0;
            frames_done <= 16'd0;
            tmo_cnt     <= 32'd0;
            job_data    <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mask        <= bus.CONFIG_DATA[NPORTS-1:0];
                        frames_left <= frame_cnt;
                        job_data    <= bus.CONFIG_DATA[NREG*W-1:W];
                        err         <= 1'b0;
                        frames_done <= 16'd0;
                    end
                end
                ST_LAUNCH: begin
                    done_seen <= '0;
                    tmo_cnt   <= 32'd0;
                end
                ST_WAIT: begin
                    done_seen <= done_seen | done_now;
                    tmo_cnt   <= tmo_cnt + 32'd1;
                    if (frame_complete) begin
                        frames_left <= frames_left - 16'd1;
                        if (frames_done != 16'hFFFF) begin
                            frames_done <= frames_done + 16'd1;
                        end
                    end else if (timed_out) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/conf_sched.md
# conf_sched

Job sequencer that sits on the consumer side of the AXI configuration register block. It accepts one configuration job per CONFIG_VALID/CONFIG_READY handshake and latches the register file. It then starts a selected set of NPORTS stream engines (DMA readers/writers, pipeline instances) for a programmed number of frames, waiting for every enabled engine to report done before each next frame. CONFIG_READY is held low for the whole job, which makes the config block's cycle counter and IRQ reflect total job time.

## Interface
- NREG, 4, number of W-bit config registers in CONFIG_DATA (≥2)
- W, 32, register width
- NPORTS, 2, number of engines sequenced (1..16)
- TIMEOUT, 0, max WAIT cycles per frame before abort; 0 disables timeout
- ACLK  in  1  clock
- ARESETN  in  1  synchronous, active-low reset; clock ACLK
- CONFIG_VALID  in  1  job offered by config block
- CONFIG_READY  out  1  high only in IDLE
- CONFIG_DATA  in  NREG*W  register file; reg k = bits [k*W +: W]
- PORT_START  out  NPORTS  one-cycle start pulse per enabled engine
- PORT_DONE  in  NPORTS  one-cycle done pulse per engine
- JOB_DATA  out  (NREG-1)*W  latched regs 1..NREG-1, stable for whole job
- BUSY  out  1  state != IDLE
- ERR  out  1  sticky timeout flag
- FRAMES_DONE  out  16  frames completed in current/last job

## Operation
- Reg 0 (CMD): bits [NPORTS-1:0] = port enable mask; bits [31:16] = frame count (0 is treated as 1).
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE: CONFIG_READY=1. On CONFIG_VALID&&CONFIG_READY: latch mask, frame count, JOB_DATA; clear ERR and FRAMES_DONE; go LAUNCH.
- LAUNCH (1 cycle): PORT_START = mask; clear done_seen; clear timeout counter; go WAIT.
- WAIT: done_seen |= PORT_DONE & mask each cycle. Done from disabled ports is ignored. Done pulses arriving in LAUNCH are ignored.
- Frame complete when (done_seen | (PORT_DONE & mask)) == mask. Then FRAMES_DONE+1. If frames remaining → LAUNCH, else → DONE.
- Mask==0: every frame completes on its first WAIT cycle.
- Timeout (TIMEOUT>0): counter increments each WAIT cycle. If the counter reaches TIMEOUT-1 without completion, set ERR and go DONE. Completion wins if both happen in the same cycle.
- DONE (1 cycle): BUSY still 1, CONFIG_READY 0; go IDLE.
- FRAMES_DONE saturates at 16'hFFFF. It holds its value in IDLE until the next job is accepted.

## Timing
- Reset values: state IDLE, CONFIG_READY=1, PORT_START=0, BUSY=0, ERR=0, FRAMES_DONE=0, JOB_DATA=0.
- Handshake at cycle t: PORT_START high at t+1 only; WAIT from t+2.
- Final done pulse at cycle d in WAIT: next LAUNCH at d+1 (START at d+1), or DONE at d+1 and IDLE/CONFIG_READY=1 at d+2.
- Minimum job of 1 frame with done at t+2: CONFIG_READY low for cycles t+1..t+3, i.e. 3 cycles.
- Per-frame overhead: 1 LAUNCH cycle plus ≥1 WAIT cycle.
- CONFIG_DATA is sampled only at the handshake. Later changes do not affect a running job.
- ARESETN low in any state: next cycle is IDLE with all outputs at reset values. Outstanding engine activity is abandoned and no START is reissued.
- CONFIG_VALID while not in IDLE is not accepted and leaves state unchanged.

## Test plan
- Reset, then CMD=0x0001_0003 with both ports done at LAUNCH+2 → PORT_START=2'b11 for exactly 1 cycle; CONFIG_READY low for 4 cycles; FRAMES_DONE=1; ERR=0.
- CMD=0x0003_0001, port0 done 5 cycles after each START → 3 START pulses on port 0 only; PORT_START[1] never asserted; FRAMES_DONE=3.
- CMD=0x0001_0003, port0 done in cycle 2 and port1 in cycle 9 of WAIT, plus a spurious port1 done during LAUNCH → completion only after the cycle-9 pulse; the LAUNCH-cycle pulse has no effect.
- TIMEOUT=8, CMD=0x0002_0001, no PORT_DONE → ERR=1 after 8 WAIT cycles; returns to IDLE; FRAMES_DONE=0; next accepted job clears ERR.
- CMD=0x0000_0000 → treated as 1 frame with empty mask; no START pulses; READY low 3 cycles; FRAMES_DONE=1.
- ARESETN low for 1 cycle mid-WAIT of a 4-frame job → IDLE, CONFIG_READY=1, FRAMES_DONE=0; a late PORT_DONE is ignored; a new job then runs normally.
